// File: rtl/pio_enc_pkg.sv
// Shared definitions for the quadrature encoder capture peripheral.
//   - Avalon-MM register word addresses
//   - CTRL and STATUS bit positions
//   - Saturation value of the interval / period counters
//   - Gray-code helper used by the x4 decoder
package pio_enc_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_POS    = 4'h1;
  localparam logic [3:0] ADDR_TARGET = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;
  localparam logic [3:0] ADDR_PERIOD = 4'h4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_DIR_INV = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STAT_TGT  = 0;
  localparam int STAT_DIR  = 1;
  localparam int STAT_QERR = 2;

  localparam logic [31:0] PERIOD_MAX = 32'hFFFF_FFFF;

  // Map an {A,B} Gray state onto its position in the forward cycle
  // 00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3, so a forward step is +1 mod 4.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: synchronizer, glitch filter and x4 decoder.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   enc_a, enc_b       asynchronous encoder channels
//   step_up, step_dn   one-cycle pulses for a forward / reverse Gray step
//   quad_err           one-cycle pulse when both channels changed at once
module quad_decoder
  import pio_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_up,
  output logic step_dn,
  output logic quad_err
);

  localparam logic [7:0] FLEN = FILTER_LEN[7:0];

  logic [SYNC_STAGES-1:0] sync_a_r, sync_b_r;
  logic [1:0] sample_s;
  logic [1:0] cand_r, filt_r;
  logic [7:0] cnt_r, cnt_n;
  logic       init_r;
  logic       accept_s;
  logic [1:0] diff_s;
  logic       up_n, dn_n, err_n;
  logic       step_up_r, step_dn_r, quad_err_r;

  assign sample_s = {sync_a_r[SYNC_STAGES-1], sync_b_r[SYNC_STAGES-1]};

  // Filter run-length, acceptance of a new stable state and step decode
  always_comb begin
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    diff_s   = 2'd0;
    up_n     = 1'b0;
    dn_n     = 1'b0;
    err_n    = 1'b0;
    if (sample_s != cand_r) begin
      cnt_n = 8'd1;
    end else if (cnt_r < FLEN) begin
      cnt_n = cnt_r + 8'd1;
    end else begin
      cnt_n = cnt_r;
    end
    // The first accepted state after reset only seeds the previous state.
    accept_s = (cnt_n >= FLEN) && (!init_r || (sample_s != filt_r));
    diff_s   = gray_idx(sample_s) - gray_idx(filt_r);
    if (accept_s && init_r) begin
      case (diff_s)
        2'd1:    up_n  = 1'b1;
        2'd3:    dn_n  = 1'b1;
        2'd2:    err_n = 1'b1;
        default: up_n  = 1'b0;
      endcase
    end else begin
      up_n = 1'b0;
    end
  end

  // Synchronizer chains, filter state and registered step pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_r   <= '0;
      sync_b_r   <= '0;
      cand_r     <= 2'b00;
      cnt_r      <= 8'd0;
      filt_r     <= 2'b00;
      init_r     <= 1'b0;
      step_up_r  <= 1'b0;
      step_dn_r  <= 1'b0;
      quad_err_r <= 1'b0;
    end else begin
      sync_a_r   <= {sync_a_r[SYNC_STAGES-2:0], enc_a};
      sync_b_r   <= {sync_b_r[SYNC_STAGES-2:0], enc_b};
      cand_r     <= sample_s;
      cnt_r      <= cnt_n;
      if (accept_s) begin
        filt_r <= sample_s;
        init_r <= 1'b1;
      end
      step_up_r  <= up_n;
      step_dn_r  <= dn_n;
      quad_err_r <= err_n;
    end
  end

  assign step_up  = step_up_r;
  assign step_dn  = step_dn_r;
  assign quad_err = quad_err_r;

endmodule

// File: rtl/pio_encoder_capture.sv
// Avalon-MM quadrature encoder capture peripheral.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   address, chipselect,
//   write, read, writedata   Avalon-MM slave request
//   readdata                 registered read data (0 when no read is active)
//   enc_a, enc_b             asynchronous encoder channels
//   irq                      target_reached & irq_en, registered
module pio_encoder_capture
  import pio_enc_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enc_a,
  input  logic        enc_b,
  output logic        irq
);

  logic step_up_s, step_dn_s, quad_err_s;

  quad_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_dec (
    .clk      (clk),
    .rst      (rst),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .step_up  (step_up_s),
    .step_dn  (step_dn_s),
    .quad_err (quad_err_s)
  );

  logic        en_r, dir_inv_r, irq_en_r;
  logic        en_n, dir_inv_n, irq_en_n;
  logic [31:0] position_r, position_n, target_r, target_n;
  logic        tgt_r, dir_r, qerr_r, tgt_n, dir_n, qerr_n;
  logic [31:0] period_r, period_n, interval_r, interval_n;
  logic [31:0] readdata_r, readdata_n, rd_data_s;
  logic        irq_r, irq_n;
  logic        wr_s, rd_s, ctrl_wr_s, pos_wr_s, tgt_wr_s, stat_wr_s, clr_s;
  logic        count_ev_s, cnt_up_s, pos_upd_s;

  // Bus decode, register next-state and read mux
  always_comb begin
    wr_s       = chipselect & write;
    rd_s       = chipselect & read & ~write;
    ctrl_wr_s  = wr_s && (address == ADDR_CTRL);
    pos_wr_s   = wr_s && (address == ADDR_POS);
    tgt_wr_s   = wr_s && (address == ADDR_TARGET);
    stat_wr_s  = wr_s && (address == ADDR_STATUS);
    clr_s      = ctrl_wr_s & writedata[CTRL_CLR];
    count_ev_s = en_r & (step_up_s | step_dn_s);
    cnt_up_s   = step_up_s ^ dir_inv_r;

    en_n       = en_r;
    dir_inv_n  = dir_inv_r;
    irq_en_n   = irq_en_r;
    if (ctrl_wr_s) begin
      en_n      = writedata[CTRL_EN];
      dir_inv_n = writedata[CTRL_DIR_INV];
      irq_en_n  = writedata[CTRL_IRQ_EN];
    end else begin
      en_n      = en_r;
    end

    // A bus write or clear overrides a coincident count.
    position_n = position_r;
    if (clr_s) begin
      position_n = 32'd0;
    end else if (pos_wr_s) begin
      position_n = writedata;
    end else if (count_ev_s) begin
      position_n = cnt_up_s ? (position_r + 32'd1) : (position_r - 32'd1);
    end else begin
      position_n = position_r;
    end
    pos_upd_s = clr_s | pos_wr_s | count_ev_s;

    target_n = tgt_wr_s ? writedata : target_r;

    // Compare against the TARGET value held before this cycle's write.
    tgt_n = tgt_r;
    if (pos_upd_s && (position_n == target_r)) begin
      tgt_n = 1'b1;
    end else if (stat_wr_s && writedata[STAT_TGT]) begin
      tgt_n = 1'b0;
    end else begin
      tgt_n = tgt_r;
    end

    qerr_n = qerr_r;
    if (quad_err_s) begin
      qerr_n = 1'b1;
    end else if (stat_wr_s && writedata[STAT_QERR]) begin
      qerr_n = 1'b0;
    end else begin
      qerr_n = qerr_r;
    end

    dir_n = count_ev_s ? cnt_up_s : dir_r;

    period_n   = period_r;
    interval_n = interval_r;
    if (count_ev_s) begin
      period_n   = (interval_r == PERIOD_MAX) ? PERIOD_MAX : (interval_r + 32'd1);
      interval_n = 32'd0;
    end else if (interval_r != PERIOD_MAX) begin
      interval_n = interval_r + 32'd1;
    end else begin
      interval_n = interval_r;
    end

    irq_n = tgt_n & irq_en_n;

    case (address)
      ADDR_CTRL:   rd_data_s = {28'd0, irq_en_r, dir_inv_r, 1'b0, en_r};
      ADDR_POS:    rd_data_s = position_r;
      ADDR_TARGET: rd_data_s = target_r;
      ADDR_STATUS: rd_data_s = {29'd0, qerr_r, dir_r, tgt_r};
      // A stalled axis reports the saturated interval rather than a stale period.
      ADDR_PERIOD: rd_data_s = (interval_r == PERIOD_MAX) ? PERIOD_MAX : period_r;
      default:     rd_data_s = 32'd0;
    endcase
    readdata_n = rd_s ? rd_data_s : 32'd0;
  end

  // Register file, counters and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r       <= 1'b0;
      dir_inv_r  <= 1'b0;
      irq_en_r   <= 1'b0;
      position_r <= 32'd0;
      target_r   <= 32'd0;
      tgt_r      <= 1'b0;
      dir_r      <= 1'b0;
      qerr_r     <= 1'b0;
      period_r   <= 32'd0;
      interval_r <= 32'd0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      en_r       <= en_n;
      dir_inv_r  <= dir_inv_n;
      irq_en_r   <= irq_en_n;
      position_r <= position_n;
      target_r   <= target_n;
      tgt_r      <= tgt_n;
      dir_r      <= dir_n;
      qerr_r     <= qerr_n;
      period_r   <= period_n;
      interval_r <= interval_n;
      readdata_r <= readdata_n;
      irq_r      <= irq_n;
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule

// File: doc/pio_encoder_capture.md
Name: pio_encoder_capture

Overview:
- Avalon-MM slave peripheral that receives quadrature encoder feedback (A/B) from the servo/stepper axis driven by the pulse-train output peripheral.
- Decodes the A/B signals in x4 mode into a signed 32-bit position.
- Measures the interval between count events for speed estimation.
- Flags arrival at a target position, with an optional interrupt to the Nios.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before A/B is accepted (range 1..255).
- SYNC_STAGES, 2: synchronizer flip-flop depth for enc_a/enc_b (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- address  in  4  register word address
- chipselect  in  1  slave select
- write  in  1  write strobe
- read  in  1  read strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- enc_a  in  1  encoder channel A (asynchronous)
- enc_b  in  1  encoder channel B (asynchronous)
- irq  out  1  interrupt, level = status.target_reached & ctrl.irq_en

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at a clk edge) clears every register:
  - ctrl, position, target, status, period, interval counter, readdata and irq all go to 0.
  - The decoder "initialized" flag is cleared.
- Register map, 32-bit word addresses:
  - 0x0 CTRL (R/W): bit0 enable, bit1 clear_pos (write-only, self-clearing, reads 0), bit2 dir_invert, bit3 irq_en.
  - 0x1 POSITION (R/W): signed count. A write preloads the count.
  - 0x2 TARGET (R/W): compare value.
  - 0x3 STATUS (R, W1C): bit0 target_reached (sticky), bit1 last_dir (1 = up, not clearable), bit2 quad_err (sticky).
  - 0x4 PERIOD (R): clk cycles between the last two count events.
  - Other addresses: writes ignored, reads return 0.
- Bus transfers:
  - Write takes effect at the clk edge where chipselect & write.
  - Read data is registered: it is valid the cycle after chipselect & read.
  - readdata returns 0 in every cycle without an active read.
  - write has priority over read if both are asserted.
- Input path:
  - SYNC_STAGES-FF synchronizer, then the filter.
  - The filtered AB state updates only after FILTER_LEN consecutive equal samples.
  - Latency from pin to filtered state is SYNC_STAGES+FILTER_LEN cycles.
- Decoding (compare new filtered AB with previous, evaluated once per filtered change):
  - 00→01→11→10→00 is +1; the reverse sequence is -1.
  - If both bits change, set quad_err and do not count.
  - dir_invert swaps the sign.
  - The first filtered value after reset only loads "previous" and never counts.
- Counting:
  - Happens only when enable=1. While disabled, the filter and previous state still track, so re-enabling never produces a spurious count.
  - Position wraps modulo 2^32 (0x7FFFFFFF+1 → 0x80000000), with no flag.
- Target detection:
  - target_reached is set on the cycle the position updates to a value equal to TARGET, whether by a count or a preload.
  - It stays set until written 1 to STATUS bit0.
  - If a set event and a W1C happen in the same cycle, set wins.
- Period measurement:
  - The interval counter increments every cycle and saturates at 0xFFFFFFFF.
  - On each counted event: PERIOD ← interval+1, interval ← 0.
  - A stalled axis therefore reads 0xFFFFFFFF once saturated; no update happens when disabled.
- Simultaneous events:
  - A POSITION write or clear_pos in the same cycle as a count event: the write/clear wins and the event is discarded (PERIOD still updates).
  - A TARGET write in the same cycle as a count event: the comparison uses the new position against the old TARGET.
- A reset asserted mid-motion discards all state. The next filtered state re-initializes without counting.

Decomposition:
- Shared package pio_enc_pkg holds:
  - Address constants ADDR_CTRL..ADDR_PERIOD.
  - CTRL bit indices (EN, CLR, DIR_INV, IRQ_EN).
  - STATUS bit indices (TGT, DIR, QERR).
  - PERIOD_MAX.
- One sub-module, quad_decoder: synchronizer, filter and x4 decode. It outputs single-cycle pulses step_up, step_dn and quad_err.
- The top level holds the registers, comparator, period counter and bus logic.

Test Plan:
- Reset then read all five registers → each reads 0x00000000 one cycle after read, irq=0.
- enable=1, FILTER_LEN=4, drive 8 forward Gray steps with 10 cycles each → POSITION=8, STATUS.bit1=1, PERIOD=10. Repeat in reverse → POSITION=0.
- Preload POSITION=0x7FFFFFFF, one forward step → 0x80000000. Preload 0, one reverse step → 0xFFFFFFFF.
- TARGET=5, irq_en=1, 5 forward steps → STATUS.bit0=1 and irq=1 on the 5th update. Write STATUS=1 → irq=0.
- Glitch on A for 3 cycles (< FILTER_LEN) → no count. Jump AB 00→11 → quad_err=1, POSITION unchanged.
- Disable, apply 3 steps, re-enable, 1 step → POSITION increments by exactly 1. Hold inputs > 2^32 cycles (forced counter) → PERIOD=0xFFFFFFFF.
